// File: rtl/vga_sync_param.sv
// vga_sync_param: parametrised VGA timing generator and pixel-stream sink with start-of-frame realignment
module vga_sync_param #(
  parameter int   CD     = 12,
  parameter int   HD     = 640,
  parameter int   HF     = 16,
  parameter int   HB     = 48,
  parameter int   HR     = 96,
  parameter int   VD     = 480,
  parameter int   VF     = 10,
  parameter int   VB     = 33,
  parameter int   VR     = 2,
  parameter logic HS_POL = 1'b0,
  parameter logic VS_POL = 1'b0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [CD:0]   si_data,
  input  logic          si_valid,
  output logic          si_ready,
  output logic          hsync,
  output logic          vsync,
  output logic [CD-1:0] rgb,
  output logic          de,
  output logic          sof,
  output logic          err
);
  localparam int HT = HD + HF + HB + HR;
  localparam int VT = VD + VF + VB + VR;
  localparam int XW = $clog2(HT);
  localparam int YW = $clog2(VT);
  typedef enum logic {SYNC, DISP} state_t;
  state_t state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, sof_q, sof_d, err_q, err_d;
  logic [CD-1:0] rgb_q, rgb_d;
  logic x_end, y_end, scan_end, video_on, origin, start, in_disp;
  logic misaligned, underflow, pixel_ok, last_px;
  assign x_end      = x_q == XW'(HT - 1);
  assign y_end      = y_q == YW'(VT - 1);
  assign scan_end   = x_end && y_end;
  assign video_on   = (x_q < XW'(HD)) && (y_q < YW'(VD));
  assign origin     = (x_q == '0) && (y_q == '0);
  assign start      = si_data[0];
  assign in_disp    = state_q == DISP;
  assign misaligned = in_disp && video_on && si_valid && start && !origin;
  assign underflow  = in_disp && video_on && !si_valid;
  assign pixel_ok   = in_disp && video_on && si_valid && !misaligned;
  assign last_px    = pixel_ok && (x_q == XW'(HD - 1)) && (y_q == YW'(VD - 1));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SYNC;
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      rgb_q   <= '0;
      de_q    <= 1'b0;
      sof_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
      de_q    <= de_d;
      sof_q   <= sof_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    x_d     = x_end ? '0 : x_q + XW'(1);
    y_d     = x_end ? (y_end ? '0 : y_q + YW'(1)) : y_q;
    state_d = in_disp ? ((misaligned || underflow || last_px) ? SYNC : DISP)
                      : ((scan_end && si_valid && start) ? DISP : SYNC);
  end
  // a start beat is held back (never flushed) so it can realign the next frame
  always_comb begin
    si_ready = in_disp ? (video_on && !(start && !origin)) : !start;
    hsync_d  = (x_q >= XW'(HD + HF) && x_q <= XW'(HD + HF + HR - 1)) ? HS_POL : ~HS_POL;
    vsync_d  = (y_q >= YW'(VD + VF) && y_q <= YW'(VD + VF + VR - 1)) ? VS_POL : ~VS_POL;
    rgb_d    = pixel_ok ? si_data[CD:1] : '0;
    de_d     = pixel_ok;
    sof_d    = pixel_ok && origin && start;
    err_d    = misaligned || underflow;
  end
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign rgb   = rgb_q;
  assign de    = de_q;
  assign sof   = sof_q;
  assign err   = err_q;
endmodule

// File: tb/tb_vga_sync_param.sv
// tb_vga_sync_param: directed scoreboard bench for vga_sync_param on a 14x7 scan timing
module tb_vga_sync_param;
  logic clk = 1'b0, reset_n = 1'b1, si_valid = 1'b0;
  logic [12:0] si_data = '0;
  logic si_ready, hsync, vsync, de, sof, err;
  logic si_ready1, hsync1, vsync1, de1, sof1, err1;
  logic [11:0] rgb, rgb1;
  typedef struct packed {logic [11:0] rgb; logic de; logic sof; logic err;} exp_t;
  exp_t eq[$];
  exp_t e;
  logic [12:0] sq[$];
  int n_cmp = 0, n_bad = 0, bx = 0, by = 0, sof_cnt = 0, err_cnt = 0, pix_cnt = 0;
  logic m_disp = 1'b0;

  vga_sync_param #(.CD(12), .HD(8), .HF(2), .HB(2), .HR(2), .VD(4), .VF(1), .VB(1), .VR(1),
    .HS_POL(1'b0), .VS_POL(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .si_data(si_data), .si_valid(si_valid), .si_ready(si_ready),
    .hsync(hsync), .vsync(vsync), .rgb(rgb), .de(de), .sof(sof), .err(err));

  vga_sync_param #(.CD(12), .HD(8), .HF(2), .HB(2), .HR(2), .VD(4), .VF(1), .VB(1), .VR(1),
    .HS_POL(1'b1), .VS_POL(1'b1)) dut_pol1 (
    .clk(clk), .reset_n(reset_n), .si_data(si_data), .si_valid(si_valid), .si_ready(si_ready1),
    .hsync(hsync1), .vsync(vsync1), .rgb(rgb1), .de(de1), .sof(sof1), .err(err1));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (x=%0d y=%0d t=%0t)", nm, act, exp, bx, by, $time);
    end
  endtask

  // scoreboard monitor: pops one expectation per displayed pixel or error pulse
  always @(negedge clk) begin
    if (de || err || sof) begin
      if (eq.size() == 0) chk("unexpected_output", 32'({de, sof, err}), 32'(0));
      else begin
        e = eq.pop_front();
        chk("rgb", 32'(rgb), 32'(e.rgb));
        chk("de", 32'(de), 32'(e.de));
        chk("sof", 32'(sof), 32'(e.sof));
        chk("err", 32'(err), 32'(e.err));
      end
      if (sof) sof_cnt++;
      if (err) err_cnt++;
      if (de) pix_cnt++;
    end else chk("rgb_idle", 32'(rgb), 32'(0));
  end

  task automatic chk_reset();
    chk("rst_hsync", 32'(hsync), 32'(1));
    chk("rst_vsync", 32'(vsync), 32'(1));
    chk("rst_rgb", 32'(rgb), 32'(0));
    chk("rst_de", 32'(de), 32'(0));
    chk("rst_sof", 32'(sof), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_hsync_pol1", 32'(hsync1), 32'(0));
    chk("rst_vsync_pol1", 32'(vsync1), 32'(0));
    chk("rst_rgb_pol1", 32'(rgb1), 32'(0));
    chk("rst_de_pol1", 32'(de1), 32'(0));
    chk("rst_sof_pol1", 32'(sof1), 32'(0));
    chk("rst_err_pol1", 32'(err1), 32'(0));
  endtask

  task automatic step(input logic gap);
    logic [12:0] d;
    logic v, vo, org, st, rdy_e, h_e, v_e, nxt;
    v = (sq.size() > 0) && !gap;
    d = (sq.size() > 0) ? sq[0] : 13'h0;
    si_valid = v;
    si_data  = d;
    #1;
    vo = bx < 8 && by < 4;
    org = bx == 0 && by == 0;
    st = d[0];
    rdy_e = m_disp ? (vo && !(st && !org)) : !st;
    chk("si_ready", 32'(si_ready), 32'(rdy_e));
    chk("si_ready_pol1", 32'(si_ready1), 32'(rdy_e));
    h_e = !(bx >= 10 && bx <= 11);
    v_e = by != 5;
    nxt = m_disp;
    if (m_disp && vo) begin
      if (!v || (st && !org)) begin
        eq.push_back(exp_t'{12'h0, 1'b0, 1'b0, 1'b1});
        nxt = 1'b0;
      end else begin
        eq.push_back(exp_t'{d[12:1], 1'b1, org && st, 1'b0});
        if (bx == 7 && by == 3) nxt = 1'b0;
      end
    end
    if (!m_disp && bx == 13 && by == 6 && v && st) nxt = 1'b1;
    if (v && rdy_e) void'(sq.pop_front());
    @(posedge clk);
    m_disp = nxt;
    bx = (bx == 13) ? 0 : bx + 1;
    if (bx == 0) by = (by == 6) ? 0 : by + 1;
    #1;
    chk("hsync", 32'(hsync), 32'(h_e));
    chk("vsync", 32'(vsync), 32'(v_e));
    chk("hsync_pol1", 32'(hsync1), 32'(!h_e));
    chk("vsync_pol1", 32'(vsync1), 32'(!v_e));
  endtask

  task automatic run(input int n, input int gx = -1, input int gy = -1);
    for (int i = 0; i < n; i++) step(bx == gx && by == gy);
  endtask

  task automatic push_frame(input logic [11:0] c0);
    sq.push_back({c0, 1'b1});
    for (int i = 1; i < 32; i++) sq.push_back({12'(i), 1'b0});
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #1 chk_reset();
    @(negedge clk);
    reset_n = 1'b1;
    // idle source for three frames
    run(294);
    chk("idle_err_cnt", 32'(err_cnt), 32'(0));
    chk("idle_pix_cnt", 32'(pix_cnt), 32'(0));
    // start beat waits a frame, then one full frame is displayed
    push_frame(12'hABC);
    run(196);
    chk("stream_sof_cnt", 32'(sof_cnt), 32'(1));
    chk("stream_pix_cnt", 32'(pix_cnt), 32'(32));
    chk("stream_src_left", 32'(sq.size()), 32'(0));
    // five flushed beats, then underflow at (3,1)
    for (int i = 0; i < 5; i++) sq.push_back({12'(32 + i), 1'b0});
    push_frame(12'hABC);
    run(5);
    chk("flush_src_left", 32'(sq.size()), 32'(32));
    run(93);
    run(98, 3, 1);
    chk("underflow_err_cnt", 32'(err_cnt), 32'(1));
    chk("underflow_sof_cnt", 32'(sof_cnt), 32'(2));
    chk("underflow_pix_cnt", 32'(pix_cnt), 32'(43));
    chk("underflow_src_left", 32'(sq.size()), 32'(0));
    // misaligned start at (5,2) realigns on the following frame
    sq.push_back({12'hABC, 1'b1});
    for (int i = 1; i <= 20; i++) sq.push_back({12'(i), 1'b0});
    sq.push_back({12'h5A5, 1'b1});
    for (int i = 1; i < 32; i++) sq.push_back({12'(256 + i), 1'b0});
    run(294);
    chk("misalign_err_cnt", 32'(err_cnt), 32'(2));
    chk("misalign_sof_cnt", 32'(sof_cnt), 32'(4));
    chk("misalign_pix_cnt", 32'(pix_cnt), 32'(96));
    chk("misalign_src_left", 32'(sq.size()), 32'(0));
    // asynchronous reset at (4,2) of a displayed frame
    push_frame(12'hABC);
    run(130);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1 chk_reset();
    chk("pre_reset_pix_cnt", 32'(pix_cnt), 32'(116));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    bx = 0;
    by = 0;
    m_disp = 1'b0;
    sq.delete();
    push_frame(12'h3C3);
    run(196);
    @(negedge clk);
    #1;
    chk("post_reset_sof_cnt", 32'(sof_cnt), 32'(6));
    chk("post_reset_pix_cnt", 32'(pix_cnt), 32'(148));
    chk("post_reset_err_cnt", 32'(err_cnt), 32'(2));
    chk("expected_drained", 32'(eq.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
